// File: rtl/pix_pkg.sv
// Shared widths, FSM state encoding and pair-packing helper for the pixel pair packer.
package pix_pkg;

  localparam int PIX_W  = 18;
  localparam int WORD_W = 36;
  localparam int ADDR_W = 19;
  localparam int ROW_W  = 10;
  localparam int COL_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LINE_WAIT = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_e;

  // First pixel of a pair occupies the upper half of the ZBT word.
  function automatic logic [WORD_W-1:0] pack_pair(input logic [PIX_W-1:0] first_pix,
                                                   input logic [PIX_W-1:0] second_pix);
    return {first_pix, second_pix};
  endfunction

endpackage

// File: rtl/pix_addr_gen.sv
// Line/word counters and ZBT address formation for the pixel pair packer.
// PIX_FIELD_INTERLEAVE_EN: when defined, row = {line[8:0], field latched at sof}.
module pix_addr_gen
  import pix_pkg::*;
#(
  parameter int MAX_WORDS = 360,
  parameter int MAX_LINES = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              field,
  input  logic              line_next,
  input  logic              line_restart,
  input  logic              word_inc,
  output logic [ADDR_W-1:0] addr,
  output logic              line_ok,
  output logic              line_next_ok,
  output logic              word_ok
);

  localparam logic [ROW_W-1:0] LINE_LIM  = ROW_W'(MAX_LINES);
  localparam logic [ROW_W-1:0] LINE_LAST = ROW_W'(MAX_LINES - 1);
  localparam logic [COL_W-1:0] WORD_LIM  = COL_W'(MAX_WORDS);

  logic [ROW_W-1:0] line_q, line_d;
  logic [COL_W-1:0] word_q, word_d;
  logic             field_q, field_d;
  logic [ROW_W-1:0] row;

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    line_d  = line_q;
    word_d  = word_q;
    field_d = field_q;
    if (frame_start) begin
      line_d  = '0;
      word_d  = '0;
      field_d = field;
    end else if (line_next) begin
      // Line count saturates at MAX_LINES so later lines stay dropped.
      if (line_q != LINE_LIM) line_d = line_q + 1'b1;
      word_d = '0;
    end else if (line_restart) begin
      word_d = '0;
    end else if (word_inc && word_ok) begin
      word_d = word_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_q  <= '0;
      word_q  <= '0;
      field_q <= 1'b0;
    end else begin
      line_q  <= line_d;
      word_q  <= word_d;
      field_q <= field_d;
    end
  end

`ifdef PIX_FIELD_INTERLEAVE_EN
  logic unused_line_msb;
  assign unused_line_msb = line_q[ROW_W-1];
  assign row             = {line_q[ROW_W-2:0], field_q};
`else
  logic unused_field;
  assign unused_field = field_q;
  assign row          = line_q;
`endif

  assign addr         = {row, word_q};
  assign line_ok      = (line_q < LINE_LIM);
  assign line_next_ok = (line_q < LINE_LAST);
  assign word_ok      = (word_q < WORD_LIM);

endmodule

// File: rtl/pix_pair_packer.sv
// Packs pairs of 18-bit RGB666 pixels into 36-bit ZBT words with line/word addressing.
// PIX_FIELD_INTERLEAVE_EN: when defined, fields interleave into even/odd rows.
module pix_pair_packer
  import pix_pkg::*;
#(
  parameter int MAX_WORDS = 360,
  parameter int MAX_LINES = 240
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  input  logic              sol,
  input  logic              field,
  output logic [WORD_W-1:0] two_pixel_vals,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_en,
  output logic              frame_done
);

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [PIX_W-1:0]   pend_pix_q, pend_pix_d;
  logic               wrote_q, wrote_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic               fd_q, fd_d;

  logic               room, take, line_next, line_restart;
  logic               line_ok, line_next_ok, word_ok;
  logic [ADDR_W-1:0]  gen_addr;

  pix_addr_gen #(
    .MAX_WORDS (MAX_WORDS),
    .MAX_LINES (MAX_LINES)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .frame_start  (sof),
    .field        (field),
    .line_next    (line_next),
    .line_restart (line_restart),
    .word_inc     (we_d),
    .addr         (gen_addr),
    .line_ok      (line_ok),
    .line_next_ok (line_next_ok),
    .word_ok      (word_ok)
  );

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_pix_d   = pend_pix_q;
    wrote_d      = wrote_q;
    data_d       = data_q;
    addr_d       = addr_q;
    we_d         = 1'b0;
    fd_d         = 1'b0;
    room         = 1'b0;
    line_next    = 1'b0;
    line_restart = 1'b0;

    // A line or field boundary always discards any unpaired pixel.
    if (sof) begin
      state_d = sol ? ST_ACTIVE : ST_LINE_WAIT;
      room    = sol;
      pend_d  = 1'b0;
      wrote_d = 1'b0;
      fd_d    = (state_q != ST_IDLE) && wrote_q;
    end else if (sol && (state_q != ST_IDLE)) begin
      pend_d = 1'b0;
      if (state_q == ST_ACTIVE) begin
        line_next = 1'b1;
        room      = line_next_ok;
        if (!line_next_ok) state_d = ST_LINE_WAIT;
      end else begin
        line_restart = 1'b1;
        room         = line_ok;
        state_d      = ST_ACTIVE;
      end
    end else if (state_q == ST_ACTIVE) begin
      room = line_ok && word_ok;
    end

    take = pix_valid && room;
    if (take) begin
      if (!pend_d) begin
        pend_d     = 1'b1;
        pend_pix_d = pix_in;
      end else begin
        pend_d  = 1'b0;
        we_d    = 1'b1;
        wrote_d = 1'b1;
        data_d  = pack_pair(pend_pix_q, pix_in);
        addr_d  = gen_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      pend_pix_q <= '0;
      wrote_q    <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_pix_q <= pend_pix_d;
      wrote_q    <= wrote_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      fd_q       <= fd_d;
    end
  end

  assign two_pixel_vals = data_q;
  assign write_addr     = addr_q;
  assign write_en       = we_q;
  assign frame_done     = fd_q;

endmodule
